muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RISC-V M-extension multiply/divide responder, sitting beside the combinational ExecutionUnit.
- The ExecutionUnit dispatches an operation when funct7 = 0000001 (auxFunc = 1). This block computes it over multiple cycles and returns the result through a valid/ready handshake.
- One operation in flight at a time; the result is registered.

Parameters:
WIDTH, 32, operand and result width in bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  request valid.
in_ready  output  1  block can accept a request; high only in IDLE.
opA  input  WIDTH  rs1 operand / dividend / multiplicand.
opB  input  WIDTH  rs2 operand / divisor / multiplier.
func  input  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
out  output  WIDTH  registered result.
busy  output  1  high in CALC, FIX or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, so in_ready = 1 and busy = 0.
  - out_valid = 0, out = 0, counter = 0; all internal datapath registers cleared.
  - Reset asserted mid-operation aborts it; no partial result is ever presented.
- FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
  - IDLE: accept on in_valid && in_ready at edge t0. Latch func, sign flags and the magnitudes of the operands. Load counter = WIDTH. Go to CALC.
  - CALC: one iteration per cycle; the counter decrements each edge. Leave for FIX on the edge where counter reaches 1, so there are exactly WIDTH CALC cycles.
  - FIX: sign correction, word selection and special-case override. Write out, set out_valid = 1, go to DONE.
  - DONE: hold out and out_valid stable while out_ready = 0. On out_ready = 1, clear out_valid and return to IDLE at that edge.
- Latency:
  - out_valid rises after edge t0 + WIDTH + 1 (33 cycles at WIDTH = 32).
  - Latency is identical for every func and for every special case.
- Throughput:
  - No IDLE bypass from DONE. in_ready rises only in the cycle after the handshake.
  - Minimum spacing between accepts is WIDTH + 3 cycles.
  - in_valid is ignored outside IDLE, and inputs are not sampled outside IDLE.
- Multiply:
  - Unsigned shift-add on magnitudes, producing a 2*WIDTH-bit product register.
  - Signedness: MUL/MULH treat both operands as signed. MULHSU treats opA as signed and opB as unsigned. MULHU treats both as unsigned.
  - If the operand signs differ, FIX negates the 2*WIDTH product (two's complement).
  - MUL returns the low WIDTH bits; MULH, MULHSU and MULHU return the high WIDTH bits.
- Divide:
  - Restoring division on magnitudes: shift the remainder left, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - DIV/REM are signed; DIVU/REMU are unsigned.
  - Quotient is negated when the operand signs differ. Remainder takes the sign of the dividend.
- Special cases (forced in FIX; the iteration still runs, so latency is unchanged):
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return opA.
  - Signed overflow (opA = 0x80000000, opB = 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Width rules:
  - All arithmetic is modulo 2^WIDTH, or modulo 2^(2*WIDTH) for the product.
  - Magnitude of 0x80000000 is 0x80000000 treated as unsigned; no overflow handling is needed for it.

Test Plan:
- MUL: opA = 8, opB = 3, func = 000, out_ready = 1 -> out = 24; out_valid high exactly 33 cycles after accept, for one cycle.
- High-word products:
  - MULH (-2) x 3 -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU (-1) x 0xFFFFFFFF -> 0xFFFFFFFF.
  - MUL 0x80000000 x 0x80000000 -> 0.
- Signed and unsigned divide:
  - DIV -20 / 3 -> 0xFFFFFFFA.
  - REM -20 / 3 -> 0xFFFFFFFE.
  - DIVU 20 / 3 -> 6.
  - REMU 20 / 3 -> 2.
  - REM 20 / -3 -> 2.
- Corner cases, each with 33-cycle latency:
  - DIV 7 / 0 -> 0xFFFFFFFF.
  - REMU 7 / 0 -> 7.
  - DIV 0x80000000 / -1 -> 0x80000000.
  - REM 0x80000000 / -1 -> 0.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid, and pulse in_valid meanwhile -> out and out_valid remain stable, in_ready = 0, the new request is not accepted. Release out_ready -> in_ready = 1 on the next cycle, and the next request produces the correct result.
- Reset mid-CALC: drive rst_n low 10 cycles after accept -> out_valid = 0, out = 0, in_ready = 1 immediately, with no clock edge required. Then release reset and run MUL 5 x 7 -> 35.

Source files
------------

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Iterative RISC-V M-extension multiply/divide responder. It sits beside the
// combinational execution unit and takes the operations dispatched with
// funct7 = 0000001. Only one operation is in flight at a time.
//
// Multiply is shift-add and divide is restoring division. Both work on
// operand magnitudes and run for WIDTH cycles. A FIX cycle then applies sign
// correction, selects the result word, and forces the special-case results.
// The latency from accept to out_valid is WIDTH + 1 cycles for every
// operation.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request valid (sampled only in IDLE)
//   in_ready   request can be accepted (high only in IDLE)
//   opA        rs1 / dividend / multiplicand
//   opB        rs2 / divisor / multiplier
//   func       funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   out        registered result
//   busy       high in CALC, FIX or DONE
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [2:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int W2 = 2 * WIDTH;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       func_reg;
  // Multiply: acc = {partial product high, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
  logic [W2-1:0]    acc_reg;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] opa_reg;       // raw dividend, returned by REM on divide-by-zero
  logic             sign_diff_reg; // operand signs differ: negate product / quotient
  logic             a_neg_reg;     // dividend negative: negate remainder
  logic             div_zero_reg;
  logic             ovf_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_reg;

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = out_valid_reg;
  assign out       = out_reg;

  // ---------------- accept-time decode ----------------
  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (func)
      F_MUL, F_MULH: begin a_signed = 1'b1; b_signed = 1'b1; end
      F_MULHSU:      begin a_signed = 1'b1; b_signed = 1'b0; end
      F_DIV, F_REM:  begin a_signed = 1'b1; b_signed = 1'b1; end
      default:       begin a_signed = 1'b0; b_signed = 1'b0; end
    endcase
    a_neg = a_signed & opA[WIDTH-1];
    b_neg = b_signed & opB[WIDTH-1];
    // The most negative value maps onto itself, which is the right unsigned
    // magnitude.
    a_mag = a_neg ? (~opA + 1'b1) : opA;
    b_mag = b_neg ? (~opB + 1'b1) : opB;
  end

  // ---------------- one iteration step ----------------
  logic [WIDTH:0]  mul_sum;
  logic [WIDTH:0]  div_shift;
  logic [WIDTH:0]  div_diff;
  logic [W2-1:0]   step_next;

  always_comb begin
    // Shift-add: add the multiplicand to the high half when the current
    // multiplier bit is set, then shift the whole accumulator right. The carry
    // moves into the top bit.
    mul_sum   = {1'b0, acc_reg[W2-1:WIDTH]} + (acc_reg[0] ? {1'b0, m_reg} : '0);
    // Restoring divide: bring the next dividend bit into the remainder, then
    // trial-subtract the divisor. The quotient bit goes into the vacated LSB.
    div_shift = {acc_reg[W2-1:WIDTH], acc_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m_reg};
    if (func_reg[2]) begin
      if (div_diff[WIDTH])
        step_next = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
      else
        step_next = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    end else begin
      step_next = {mul_sum, acc_reg[WIDTH-1:1]};
    end
  end

  // ---------------- FIX-cycle result selection ----------------
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo, rem, quo_fix, rem_fix;
  logic [WIDTH-1:0] fix_out;

  always_comb begin
    prod_fix = sign_diff_reg ? (~acc_reg + 1'b1) : acc_reg;
    quo      = acc_reg[WIDTH-1:0];
    rem      = acc_reg[W2-1:WIDTH];
    quo_fix  = sign_diff_reg ? (~quo + 1'b1) : quo;
    rem_fix  = a_neg_reg ? (~rem + 1'b1) : rem;
    fix_out  = '0;
    case (func_reg)
      F_MUL:                     fix_out = prod_fix[WIDTH-1:0];
      F_MULH, F_MULHSU, F_MULHU: fix_out = prod_fix[W2-1:WIDTH];
      F_DIV, F_DIVU: begin
        if (div_zero_reg)  fix_out = '1;
        else if (ovf_reg)  fix_out = MIN_NEG;
        else               fix_out = quo_fix;
      end
      F_REM, F_REMU: begin
        if (div_zero_reg)  fix_out = opa_reg;
        else if (ovf_reg)  fix_out = '0;
        else               fix_out = rem_fix;
      end
      default:                   fix_out = '0;
    endcase
  end

  // ---------------- FSM and datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      func_reg      <= '0;
      acc_reg       <= '0;
      m_reg         <= '0;
      opa_reg       <= '0;
      sign_diff_reg <= 1'b0;
      a_neg_reg     <= 1'b0;
      div_zero_reg  <= 1'b0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            func_reg      <= func;
            opa_reg       <= opA;
            sign_diff_reg <= a_neg ^ b_neg;
            a_neg_reg     <= a_neg;
            div_zero_reg  <= func[2] && (opB == '0);
            ovf_reg       <= (func == F_DIV || func == F_REM) &&
                             (opA == MIN_NEG) && (opB == '1);
            if (func[2]) begin
              acc_reg <= {{WIDTH{1'b0}}, a_mag};
              m_reg   <= b_mag;
            end else begin
              acc_reg <= {{WIDTH{1'b0}}, b_mag};
              m_reg   <= a_mag;
            end
            cnt_reg   <= CNT_W'(WIDTH);
            state_reg <= CALC;
          end
        end
        CALC: begin
          acc_reg <= step_next;
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1))
            state_reg <= FIX;
        end
        FIX: begin
          out_reg       <= fix_out;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed bench for muldiv_unit. A table of {func, opA, opB, expected}
// records is applied in order, and each result and its latency are checked.
// Hand-written sequences then cover backpressure and a reset during CALC.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic [2:0]   func;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opA       (opA),
    .opB       (opB),
    .func      (func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request, wait for its result and accept it (out_ready = 1).
  task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output int lat);
    @(negedge clk);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; func = f; opA = a; opB = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out;
    @(posedge clk); #1;
    chk("out_valid_one_cycle", {31'd0, out_valid}, 32'd0);
  endtask

  vec_t vecs[20];
  logic [W-1:0] res;
  int lat;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opA = '0; opB = '0; func = '0;

    vecs[0]  = '{3'b000, 32'd8,        32'd3,        32'd24};
    vecs[1]  = '{3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h00000000};
    vecs[5]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[6]  = '{3'b010, 32'h80000000, 32'd2,        32'hFFFFFFFF};
    vecs[7]  = '{3'b100, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA};
    vecs[8]  = '{3'b110, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE};
    vecs[9]  = '{3'b101, 32'd20,       32'd3,        32'd6};
    vecs[10] = '{3'b111, 32'd20,       32'd3,        32'd2};
    vecs[11] = '{3'b110, 32'd20,       32'hFFFFFFFD, 32'd2};
    vecs[12] = '{3'b100, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3};
    vecs[13] = '{3'b110, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF};
    vecs[14] = '{3'b101, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF};
    vecs[15] = '{3'b100, 32'd7,        32'd0,        32'hFFFFFFFF};
    vecs[16] = '{3'b111, 32'd7,        32'd0,        32'd7};
    vecs[17] = '{3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9};
    vecs[18] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[19] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};

    // Reset state
    #12;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out",       out,                32'd0);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat);
      $display("vec %0d func=%b a=0x%08h b=0x%08h out=0x%08h lat=%0d",
               i, vecs[i].f, vecs[i].a, vecs[i].b, res, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, LAT);
    end

    // Backpressure: DIVU 100/7 = 14, hold out_ready low and pulse in_valid.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; func = 3'b101; opA = 32'd100; opB = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", lat, LAT);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; func = 3'b000; opA = 32'd9; opB = 32'd9;
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_hold%0d_out", k),   out,                32'd14);
      chk($sformatf("bp_hold%0d_ready", k), {31'd0, in_ready},  32'd0);
    end
    $display("backpressure out=0x%08h held 5 cycles", out);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready},  32'd1);
    run_op(3'b000, 32'd6, 32'd7, res, lat);
    $display("post-backpressure MUL 6*7 out=0x%08h lat=%0d", res, lat);
    chk("bp_next_result",  res, 32'd42);
    chk("bp_next_latency", lat, LAT);

    // Reset mid-CALC: asserted between edges, checked before any edge.
    @(negedge clk);
    in_valid = 1'b1; func = 3'b001; opA = 32'h12345678; opB = 32'h9ABCDEF0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    chk("midcalc_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out",       out,                32'd0);
    chk("arst_busy",      {31'd0, busy},      32'd0);
    $display("async reset mid-CALC out=0x%08h in_ready=%0b", out, in_ready);
    @(negedge clk); rst_n = 1'b1;
    run_op(3'b000, 32'd5, 32'd7, res, lat);
    $display("post-reset MUL 5*7 out=0x%08h lat=%0d", res, lat);
    chk("post_reset_result",  res, 32'd35);
    chk("post_reset_latency", lat, LAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
